number_parser: RTL

NUMBER_PARSER -- requirements
Module: number_parser

---
 rtl/forthsuper_pkg.sv | 22 ++
 rtl/mb8_io.sv | 11 +
 rtl/number_digit.sv | 31 +++
 rtl/number_parser.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/forthsuper_pkg.sv
// Shared types and constants for the forthsuper number parser:
// parser state enum, ASCII codes, number bases and counter width.
package forthsuper_pkg;

    typedef enum logic [1:0] {
        IDL,
        SKP,
        DIG,
        FIN
    } parser_sts;

    localparam logic [7:0] CH_SPC = 8'h20;
    localparam logic [7:0] CH_NUL = 8'h00;
    localparam logic [7:0] CH_MIN = 8'h2D;
    localparam logic [7:0] CH_DLR = 8'h24;

    localparam logic [4:0] BASE_DEC = 5'd10;
    localparam logic [4:0] BASE_HEX = 5'd16;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mb8_io.sv
// Memory block port bundle: address (ai) and write enable (we).
// master drives both, slave (the memory) receives them.
interface mb8_io #(
    parameter int ASZ = 17
);
    logic [ASZ-1:0] ai;
    logic           we;

    modport master (output ai, output we);
    modport slave  (input  ai, input  we);
endinterface

// File: rtl/number_digit.sv
// Combinational digit decode: byte b in the current base -> dv (valid), dval.
// Ports: b (byte), base (10 or 16), dv, dval (4-bit value). Macro NUMBER_HEX_EN adds a-f/A-F.
module number_digit #(
    parameter int DSZ = 8
) (
    input  logic [DSZ-1:0] b,
    input  logic [4:0]     base,
    output logic           dv,
    output logic [3:0]     dval
);
    logic is_dig;

    always_comb begin
        is_dig = 1'b0;
        dval   = 4'd0;
        if (b >= DSZ'(8'h30) && b <= DSZ'(8'h39)) begin
            is_dig = 1'b1;
            dval   = b[3:0];
        end
`ifdef NUMBER_HEX_EN
        // 'a'/'A' have low nibble 1, so +9 maps them onto 10..15
        else if ((b >= DSZ'(8'h61) && b <= DSZ'(8'h66)) ||
                 (b >= DSZ'(8'h41) && b <= DSZ'(8'h46))) begin
            is_dig = 1'b1;
            dval   = b[3:0] + 4'd9;
        end
`endif
        dv = is_dig && ({1'b0, dval} < base);
    end

endmodule

// File: rtl/number_parser.sv
// Streams a TIB token from memory one byte per cycle and converts it to a signed number.
// Ports: clk, rst (async high), mb_if (ai/we master), en, aw (token addr), vw (read byte),
// bsy, ok, val, tib (address after token). Macro NUMBER_HEX_EN enables '$' hex prefix.
module number_parser #(
    parameter int DSZ = 8,
    parameter int ASZ = 17,
    parameter int WSZ = 32
) (
    input  logic           clk,
    input  logic           rst,
    mb8_io.master          mb_if,
    input  logic           en,
    input  logic [ASZ-1:0] aw,
    input  logic [DSZ-1:0] vw,
    output logic           bsy,
    output logic           ok,
    output logic [WSZ-1:0] val,
    output logic [ASZ-1:0] tib
);
    import forthsuper_pkg::*;

    parser_sts      st_q, st_d;
    logic [ASZ-1:0] a_q, a_d;
    logic [WSZ-1:0] acc_q, acc_d;
    logic           neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           bsy_q, bsy_d;
    logic           ok_q, ok_d;
    logic [WSZ-1:0] val_q, val_d;
    logic [ASZ-1:0] tib_q, tib_d;
    logic [4:0]     base_w;
`ifdef NUMBER_HEX_EN
    logic [4:0]     base_q, base_d;
    assign base_w = base_q;
`else
    assign base_w = BASE_DEC;
`endif

    logic           dv;
    logic [3:0]     dval;
    logic           is_spc, is_nul, is_min;
    logic [WSZ-1:0] acc_mul;
    logic           fin_go, fin_ok;
    logic [ASZ-1:0] fin_tib;

    number_digit #(.DSZ(DSZ)) u_digit (
        .b    (vw),
        .base (base_w),
        .dv   (dv),
        .dval (dval)
    );

    assign is_spc = (vw == DSZ'(CH_SPC));
    assign is_nul = (vw == DSZ'(CH_NUL));
    assign is_min = (vw == DSZ'(CH_MIN));

    assign mb_if.ai = (st_q == IDL) ? aw : a_q;
    assign mb_if.we = 1'b0;

`ifdef NUMBER_HEX_EN
    logic is_dlr;
    assign is_dlr  = (vw == DSZ'(CH_DLR));
    assign acc_mul = (base_q == BASE_HEX) ? (acc_q << 4)
                                          : (acc_q << 3) + (acc_q << 1);
`else
    assign acc_mul = (acc_q << 3) + (acc_q << 1);
`endif

    always_comb begin
        st_d    = st_q;
        a_d     = a_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        bsy_d   = bsy_q;
        ok_d    = ok_q;
        val_d   = val_q;
        tib_d   = tib_q;
`ifdef NUMBER_HEX_EN
        base_d  = base_q;
`endif
        fin_go  = 1'b0;
        fin_ok  = 1'b0;
        fin_tib = a_q;

        unique case (st_q)
            IDL: begin
                if (en) begin
                    a_d   = aw + ASZ'(1);
                    acc_d = '0;
                    neg_d = 1'b0;
                    cnt_d = '0;
                    bsy_d = 1'b1;
                    ok_d  = 1'b0;
                    st_d  = SKP;
`ifdef NUMBER_HEX_EN
                    base_d = BASE_DEC;
`endif
                end
            end
            SKP: begin
                if (!en) begin
                    st_d  = IDL;
                    bsy_d = 1'b0;
                    ok_d  = 1'b0;
                end else if (is_spc) begin
                    a_d = a_q + ASZ'(1);
                end else if (is_min) begin
                    neg_d = 1'b1;
                    a_d   = a_q + ASZ'(1);
                    st_d  = DIG;
`ifdef NUMBER_HEX_EN
                end else if (is_dlr) begin
                    base_d = BASE_HEX;
                    a_d    = a_q + ASZ'(1);
`endif
                end else if (dv) begin
                    acc_d = WSZ'(dval);
                    cnt_d = CNT_W'(1);
                    a_d   = a_q + ASZ'(1);
                    st_d  = DIG;
                end else if (is_nul) begin
                    fin_go  = 1'b1;
                    fin_tib = a_q - ASZ'(1);
                end else begin
                    fin_go  = 1'b1;
                end
            end
            DIG: begin
                if (!en) begin
                    st_d  = IDL;
                    bsy_d = 1'b0;
                    ok_d  = 1'b0;
                end else if (dv) begin
                    acc_d = acc_mul + WSZ'(dval);
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    a_d   = a_q + ASZ'(1);
`ifdef NUMBER_HEX_EN
                // '$' right after '-' still selects hex
                end else if (is_dlr && cnt_q == '0 && base_q == BASE_DEC) begin
                    base_d = BASE_HEX;
                    a_d    = a_q + ASZ'(1);
`endif
                end else if (is_spc) begin
                    fin_go = 1'b1;
                    fin_ok = (cnt_q != '0);
                end else if (is_nul) begin
                    fin_go  = 1'b1;
                    fin_ok  = (cnt_q != '0);
                    fin_tib = a_q - ASZ'(1);
                end else begin
                    fin_go = 1'b1;
                end
            end
            FIN: begin
                if (!en) st_d = IDL;
            end
            default: st_d = IDL;
        endcase

        if (fin_go) begin
            st_d  = FIN;
            bsy_d = 1'b0;
            ok_d  = fin_ok;
            tib_d = fin_tib;
            val_d = fin_ok ? (neg_q ? -acc_q : acc_q) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= IDL;
            a_q    <= '0;
            acc_q  <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            bsy_q  <= 1'b0;
            ok_q   <= 1'b0;
            val_q  <= '0;
            tib_q  <= '0;
`ifdef NUMBER_HEX_EN
            base_q <= BASE_DEC;
`endif
        end else begin
            st_q   <= st_d;
            a_q    <= a_d;
            acc_q  <= acc_d;
            neg_q  <= neg_d;
            cnt_q  <= cnt_d;
            bsy_q  <= bsy_d;
            ok_q   <= ok_d;
            val_q  <= val_d;
            tib_q  <= tib_d;
`ifdef NUMBER_HEX_EN
            base_q <= base_d;
`endif
        end
    end

    assign bsy = bsy_q;
    assign ok  = ok_q;
    assign val = val_q;
    assign tib = tib_q;

endmodule
